// File: rtl/weight_stream_pkg.sv
// Shared types and defaults for the weight stream scheduler.
//   state_e        : scheduler FSM states
//   inflight_tag_t : one entry of the ROM read tag pipeline
package weight_stream_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic vld;
    logic last;
  } inflight_tag_t;

  localparam int unsigned ROM_LATENCY_DEFAULT = 2;
  localparam int unsigned FIFO_DEPTH_DEFAULT  = 4;

endpackage

// File: rtl/weight_stream_fifo.sv
// First-word-fall-through FIFO with registered storage.
// Ports:
//   clk, rst         : clock, asynchronous active-low reset
//   push, push_data  : write request and word
//   pop              : read request (ignored while empty)
//   head_data        : entry at the head of the queue
//   head_valid       : queue non-empty
//   count            : number of stored entries
// Push while full is accepted only together with a pop in the same cycle.
module weight_stream_fifo #(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_data,
  output logic                 head_valid,
  output logic [CNT_WIDTH-1:0] count
);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full;
  logic                 push_ok;
  logic                 pop_ok;

  assign full       = (count_q == CNT_WIDTH'(DEPTH));
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];
  assign count      = count_q;

  assign pop_ok  = pop && head_valid;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_WIDTH'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_WIDTH'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end
  end

endmodule

// File: rtl/weight_stream_scheduler.sv
// Streams the contents of a weight ROM (registered read, address/ce interface) as a
// valid/ready stream, replaying all ADDR_RANGE words num_passes times.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   start, num_passes              : run request (IDLE only) and pass count
//   busy, done                     : run in progress, one-cycle completion pulse
//   rom_address0, rom_ce0, rom_q0  : ROM read port
//   data_out, data_out_valid,
//   data_out_ready, data_out_last  : output stream, last marks address ADDR_RANGE-1
// Reads are only issued while the FIFO has room for every read already in flight, so a
// stalled consumer never causes a returning word to be dropped.
module weight_stream_scheduler
  import weight_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned ADDR_RANGE  = 576,
  parameter int unsigned ADDR_WIDTH  = $clog2(ADDR_RANGE) + 1,
  parameter int unsigned ROM_LATENCY = ROM_LATENCY_DEFAULT,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter int unsigned PASS_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_address0,
  output logic                  rom_ce0,
  input  logic [DATA_WIDTH-1:0] rom_q0,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned INFL_WIDTH = $clog2(ROM_LATENCY + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PASS_WIDTH-1:0] pass_q, pass_d;
  logic [PASS_WIDTH-1:0] passes_q, passes_d;
  inflight_tag_t         tag_q [ROM_LATENCY];
  inflight_tag_t         tag_in;
  inflight_tag_t         tag_out;

  logic [INFL_WIDTH-1:0] inflight;
  logic [CNT_WIDTH-1:0]  fifo_count;
  logic [DATA_WIDTH:0]   fifo_head;
  logic                  fifo_valid;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  credit_ok;
  logic                  issue;
  logic                  addr_last;
  logic                  fifo_drains;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + INFL_WIDTH'(tag_q[i].vld);
    end
  end

  // Count every tag still in the pipe, including the one landing this cycle.
  assign credit_ok = (32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH;
  assign issue     = (state_q == StIssue) && credit_ok;
  assign addr_last = (addr_q == ADDR_WIDTH'(ADDR_RANGE - 1));

  assign rom_ce0      = (state_q == StIssue) || (state_q == StDrain);
  assign rom_address0 = addr_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);

  always_comb begin
    tag_in.vld  = issue;
    tag_in.last = issue && addr_last;
  end

  assign tag_out   = tag_q[ROM_LATENCY-1];
  assign fifo_push = rom_ce0 && tag_out.vld;
  assign fifo_pop  = fifo_valid && data_out_ready;

  // FIFO is empty after this cycle's handshake, so done lands right after it.
  assign fifo_drains = (fifo_count == '0) ||
                       ((fifo_count == CNT_WIDTH'(1)) && fifo_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else if (rom_ce0) begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (num_passes == '0) begin
            state_d = StDone;
          end else begin
            passes_d = num_passes;
            addr_d   = '0;
            pass_d   = '0;
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        if (issue) begin
          if (addr_last) begin
            addr_d = '0;
            pass_d = pass_q + PASS_WIDTH'(1);
            if (pass_q == passes_q - PASS_WIDTH'(1)) begin
              state_d = StDrain;
            end
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      StDrain: begin
        if ((inflight == '0) && fifo_drains) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      pass_q   <= '0;
      passes_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pass_q   <= pass_d;
      passes_q <= passes_d;
    end
  end

  weight_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  ({tag_out.last, rom_q0}),
    .pop        (fifo_pop),
    .head_data  (fifo_head),
    .head_valid (fifo_valid),
    .count      (fifo_count)
  );

  assign data_out       = fifo_head[DATA_WIDTH-1:0];
  assign data_out_last  = fifo_valid && fifo_head[DATA_WIDTH];
  assign data_out_valid = fifo_valid;

endmodule

// File: tb/tb_weight_stream_scheduler.sv
// Self-checking bench for weight_stream_scheduler with a 4-word ROM holding its address.
module tb_weight_stream_scheduler;

  localparam int unsigned DW = 16;
  localparam int unsigned AR = 4;
  localparam int unsigned AW = $clog2(AR) + 1;
  localparam int unsigned PW = 8;
  localparam int unsigned FD = 4;
  localparam int unsigned RL = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [PW-1:0] num_passes;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_address0;
  logic          rom_ce0;
  logic [DW-1:0] rom_q0;
  logic [DW-1:0] rom_stage;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready;
  logic          data_out_last;

  int n_checks;
  int n_errors;

  weight_stream_scheduler #(
    .DATA_WIDTH  (DW),
    .ADDR_RANGE  (AR),
    .ADDR_WIDTH  (AW),
    .ROM_LATENCY (RL),
    .FIFO_DEPTH  (FD),
    .PASS_WIDTH  (PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_passes     (num_passes),
    .busy           (busy),
    .done           (done),
    .rom_address0   (rom_address0),
    .rom_ce0        (rom_ce0),
    .rom_q0         (rom_q0),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage registered ROM; word content equals its address.
  always @(posedge clk) begin
    if (rom_ce0) begin
      rom_stage <= DW'(rom_address0);
      rom_q0    <= rom_stage;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: ready always high; mode 1: ~30% random ready with a 10-cycle low window.
  // inject_cyc > 0 pulses a stray start (5 passes) at that cycle of the run.
  task automatic do_run(input int passes, input int mode, input int inject_cyc);
    logic [DW:0] exp_q[$];
    logic [DW:0] e;
    logic [DW:0] held;
    logic        stalled;
    logic        ce_seen;
    int          total, cyc, got_n, first_valid, last_hs, done_cyc, done_n, max_cnt, after;

    exp_q.delete();
    for (int p = 0; p < passes; p++) begin
      for (int a = 0; a < int'(AR); a++) begin
        exp_q.push_back({(a == int'(AR) - 1) ? 1'b1 : 1'b0, DW'(a)});
      end
    end
    total = exp_q.size();

    @(negedge clk);
    start          = 1'b1;
    num_passes     = PW'(passes);
    data_out_ready = 1'b1;
    cyc = 0; got_n = 0; first_valid = -1; last_hs = -1; done_cyc = -1;
    done_n = 0; max_cnt = 0; after = 0; ce_seen = 1'b0; stalled = 1'b0; held = '0;

    while (cyc < 300 && after < 3) begin
      @(negedge clk);
      cyc++;
      start = (cyc == inject_cyc);
      if (cyc == inject_cyc) num_passes = PW'(5);

      if (rom_ce0) ce_seen = 1'b1;
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      if (cyc == 1) check("busy_run", busy, 1);
      if (stalled) begin
        check("stall_valid", data_out_valid, 1);
        check("stall_data", {data_out_last, data_out}, held);
      end

      if (mode == 0) data_out_ready = 1'b1;
      else if (cyc >= 8 && cyc < 18) data_out_ready = 1'b0;
      else data_out_ready = ($urandom_range(0, 9) < 3);

      stalled = data_out_valid && !data_out_ready;
      held    = {data_out_last, data_out};
      if (data_out_valid && first_valid < 0) first_valid = cyc;

      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", got_n + 1, total);
        end else begin
          e = exp_q.pop_front();
          check("word", data_out, e[DW-1:0]);
          check("last", data_out_last, e[DW]);
        end
        got_n++;
        last_hs = cyc;
      end

      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
        check("done_words", got_n, total);
      end
      if (done_cyc >= 0) begin
        if (cyc == done_cyc + 1) check("busy_after_done", busy, 0);
        after++;
      end
    end

    data_out_ready = 1'b1;
    check("done_seen", (done_cyc >= 0), 1);
    check("done_pulses", done_n, 1);
    check("word_count", got_n, total);
    check("fifo_overflow", (max_cnt > int'(FD)), 0);
    if (mode == 0) begin
      check("done_cycle", done_cyc, (total == 0) ? 1 : 4 + total);
      if (total > 0) check("first_valid_cycle", first_valid, 4);
    end else begin
      check("done_after_hs", done_cyc, last_hs + 1);
    end
    if (passes == 0) begin
      check("zero_no_ce", ce_seen, 0);
      check("zero_no_valid", (first_valid >= 0), 0);
    end
  endtask

  initial begin
    int n;
    int cyc;
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b0;
    start          = 1'b0;
    num_passes     = '0;
    data_out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ce", rom_ce0, 0);
    check("rst_addr", rom_address0, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_last", data_out_last, 0);
    check("rst_data", data_out, 0);
    rst = 1'b1;

    do_run(1, 0, 0);
    do_run(3, 0, 0);
    do_run(2, 1, 0);
    do_run(2, 1, 0);
    do_run(0, 0, 0);
    do_run(2, 0, 3);

    // Reset in the middle of a two-pass run.
    @(negedge clk);
    start          = 1'b1;
    num_passes     = PW'(2);
    data_out_ready = 1'b1;
    n   = 0;
    cyc = 0;
    while (n < 3 && cyc < 50) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (data_out_valid) begin
        check("rst_pre_word", data_out, n);
        n++;
      end
    end
    check("rst_pre_words", n, 3);
    @(negedge clk);
    check("rst_pre_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", data_out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ce", rom_ce0, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_no_done", done, 0);
    end
    rst = 1'b1;
    do_run(1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
